hdmi_output_sequencer: RTL
==========================

# hdmi_output_sequencer

Video-domain controller between the DDR3 frame buffer read port and the DVI/HDMI transmitter. It holds the display on filler until DDR3 calibration completes and the camera delivers a run of stable frames. It then switches to live frame-buffer pixels, and falls back to filler when camera frames stop. It also delay-aligns the timing generator's syncs with the frame buffer's read latency and gates the read-side vsync to the frame buffer.

## Interface

Parameters:
- SYNC_DLY, 5: pipeline stages applied to hs/vs/de (≥2).
- WARMUP_FRAMES, 4: consecutive camera frames required before going LIVE (1..15).
- WDOG_FRAMES, 3: consecutive output frames without a camera frame before declaring LOST (1..15).
- BAR_SHIFT, 7: log2 of the colour-bar width in pixels (test pattern only).

Ports:
- video_clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- calib_done  in  1  DDR3 init_calib_complete; asynchronous, synchronised internally.
- cam_vs_n  in  1  camera vsync, active-low, from the cmos_pclk domain; asynchronous.
- tim_hs_n  in  1  timing generator hsync, active-low.
- tim_vs_n  in  1  timing generator vsync, active-low.
- tim_de  in  1  timing generator data enable.
- fb_de  in  1  frame buffer output data valid.
- fb_data  in  16  frame buffer pixel, RGB565.
- fb_vs_n  out  1  vsync to the frame buffer read side.
- out_hs_n  out  1  delayed hsync to TMDS.
- out_vs_n  out  1  delayed vsync to TMDS.
- out_de  out  1  delayed data enable to TMDS.
- out_rgb  out  16  RGB565 pixel to TMDS.
- state  out  2  current state: 0 WAIT_CAL, 1 WARMUP, 2 LIVE, 3 LOST.
- lost_cnt  out  8  saturating count of LIVE→LOST events.

## Operation

Input conditioning:
- calib_done and cam_vs_n each pass through a 2-FF synchroniser.
- cam_frame is a one-cycle pulse on a synchronised cam_vs_n falling edge.
- The output frame boundary is a tim_vs_n falling edge, detected with one register.

Frame tracking:
- The seen flag is set by cam_frame and cleared at each boundary.
- If cam_frame and a boundary coincide, the pulse counts for the interval that is ending.

State machine (transitions only at a boundary, except the calib rule):
- WAIT_CAL: synchronised calib_done=1 → WARMUP, warm_cnt=0.
- WARMUP: seen → warm_cnt+1; reaching WARMUP_FRAMES → LIVE with miss_cnt=0. Not seen → warm_cnt=0.
- LIVE: seen → miss_cnt=0. Not seen → miss_cnt+1; reaching WDOG_FRAMES → LOST and lost_cnt+1 (saturates at 255).
- LOST: seen → WARMUP, warm_cnt=0.
- Synchronised calib_done=0 in any state → WAIT_CAL on the next cycle, counters cleared. This rule does not wait for a boundary.

Datapath:
- hs/vs/de are delayed SYNC_DLY registers; out_* is the last tap.
- out_rgb is registered one cycle from its selection:
  - state==LIVE and fb_de → fb_data.
  - Otherwise → filler.
- fb_vs_n equals tim_vs_n in every state except WAIT_CAL, where it is held at 1.

## Timing

- Reset values:
  - out_hs_n=1, out_vs_n=1, out_de=0, out_rgb=0, fb_vs_n=1.
  - state=0, lost_cnt=0.
  - Delay line: hs/vs stages=1, de stages=0.
- Sync latency is SYNC_DLY cycles from tim_* to out_*.
- out_rgb has 1-cycle latency from fb_data/fb_de.
- calib_done to state change is 3 cycles (2 sync + 1).
- A cam_vs_n edge is recognised 3 cycles after it becomes stable.
- cam_vs_n must stay low for ≥2 video_clk cycles.
- A state change at a boundary takes effect on out_rgb from the next cycle, which falls within vertical blanking, so no tearing.
- Counters never wrap; warm_cnt and miss_cnt are 4 bits.

## Configuration

- TEST_PATTERN_EN defined: filler is 8 vertical colour bars.
  - x counter counts delayed-de cycles and clears while de is low.
  - Bar index = x[BAR_SHIFT+2:BAR_SHIFT].
  - Colours in index order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- TEST_PATTERN_EN undefined: filler is 16'h0000, and the x counter is absent.

## Test plan

- Reset, then calib_done=1 with no camera vsync: state=1 after 3 cycles; out_rgb=filler; fb_vs_n follows tim_vs_n.
- Four camera frames between five successive output boundaries: state=2 at the 4th counted boundary; with fb_de=1 and fb_data=16'h1234, out_rgb=1234 one cycle later.
- LIVE, then camera vsync stopped: after 3 boundaries, state=3 and lost_cnt=1. Camera resumes → state=1, then state=2 after 4 further frames.
- cam_frame on the same cycle as a boundary: counted once, so warm_cnt increments once.
- calib_done dropped mid-frame while LIVE: state=0 within 3 cycles; fb_vs_n=1; out_rgb=filler.
- With TEST_PATTERN_EN and BAR_SHIFT=7, non-LIVE: pixel 0 gives FFFF, pixel 128 gives FFE0, pixel 896 gives 0000. out_de lags tim_de by exactly 5 cycles.

Source files
------------

// File: rtl/hdmi_output_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_output_sequencer
// Description : Video-domain sequencer between the DDR3 frame-buffer read
//               port and the TMDS transmitter. It shows filler until DDR3
//               calibration is done and the camera has produced a run of
//               frames, then passes live pixels. It falls back to filler when
//               camera frames stop. It also delay-aligns the timing syncs and
//               gates the read-side vsync.
//               Optional build macro: TEST_PATTERN_EN (colour-bar filler).
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_output_sequencer #(
  parameter int SYNC_DLY      = 5,
  parameter int WARMUP_FRAMES = 4,
  parameter int WDOG_FRAMES   = 3,
  parameter int BAR_SHIFT     = 7
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic        calib_done,
  input  logic        cam_vs_n,
  input  logic        tim_hs_n,
  input  logic        tim_vs_n,
  input  logic        tim_de,
  input  logic        fb_de,
  input  logic [15:0] fb_data,
  output logic        fb_vs_n,
  output logic        out_hs_n,
  output logic        out_vs_n,
  output logic        out_de,
  output logic [15:0] out_rgb,
  output logic [1:0]  state,
  output logic [7:0]  lost_cnt
);

  typedef enum logic [1:0] {
    ST_WAIT_CAL = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_LIVE     = 2'd2,
    ST_LOST     = 2'd3
  } state_t;

  localparam logic [3:0] c_warm_target = 4'(WARMUP_FRAMES);
  localparam logic [3:0] c_wdog_target = 4'(WDOG_FRAMES);

  // Out-of-range parameters would silently break the counters or delay line.
  if (SYNC_DLY < 2 || WARMUP_FRAMES < 1 || WARMUP_FRAMES > 15 ||
      WDOG_FRAMES < 1 || WDOG_FRAMES > 15 || BAR_SHIFT < 0) begin : g_param_check
    $error("hdmi_output_sequencer: parameter out of range");
  end

  logic                r_calib_meta, r_calib_sync;
  logic                r_cam_meta, r_cam_sync, r_cam_prev;
  logic                r_tim_vs_prev;
  logic                r_seen;
  state_t              r_state, w_state_nxt;
  logic [3:0]          r_warm_cnt, w_warm_nxt;
  logic [3:0]          r_miss_cnt, w_miss_nxt;
  logic [7:0]          r_lost_cnt, w_lost_nxt;
  logic [SYNC_DLY-1:0] r_hs_dly, r_vs_dly, r_de_dly;
  logic [15:0]         r_rgb;
  logic [15:0]         w_filler;
  logic                w_cam_frame, w_boundary, w_seen_eff;

  // Synchronise the asynchronous inputs and keep one tap of history for edges.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_calib_meta  <= 1'b0;
      r_calib_sync  <= 1'b0;
      r_cam_meta    <= 1'b1;
      r_cam_sync    <= 1'b1;
      r_cam_prev    <= 1'b1;
      r_tim_vs_prev <= 1'b1;
    end else begin
      r_calib_meta  <= calib_done;
      r_calib_sync  <= r_calib_meta;
      r_cam_meta    <= cam_vs_n;
      r_cam_sync    <= r_cam_meta;
      r_cam_prev    <= r_cam_sync;
      r_tim_vs_prev <= tim_vs_n;
    end
  end

  assign w_cam_frame = r_cam_prev & ~r_cam_sync;
  assign w_boundary  = r_tim_vs_prev & ~tim_vs_n;
  // A camera frame landing on the boundary cycle belongs to the ending interval.
  assign w_seen_eff  = r_seen | w_cam_frame;

  // Seen flag: one camera frame observed in the current output frame interval.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n)           r_seen <= 1'b0;
    else if (w_boundary)  r_seen <= 1'b0;
    else if (w_cam_frame) r_seen <= 1'b1;
  end

  // State and counter registers.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT_CAL;
      r_warm_cnt <= 4'd0;
      r_miss_cnt <= 4'd0;
      r_lost_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_warm_cnt <= w_warm_nxt;
      r_miss_cnt <= w_miss_nxt;
      r_lost_cnt <= w_lost_nxt;
    end
  end

  // Next-state logic: calibration loss overrides, everything else waits for a boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_warm_nxt  = r_warm_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_lost_nxt  = r_lost_cnt;
    if (!r_calib_sync) begin
      w_state_nxt = ST_WAIT_CAL;
      w_warm_nxt  = 4'd0;
      w_miss_nxt  = 4'd0;
    end else begin
      case (r_state)
        ST_WAIT_CAL: begin
          w_state_nxt = ST_WARMUP;
          w_warm_nxt  = 4'd0;
        end
        ST_WARMUP: begin
          if (w_boundary) begin
            if (w_seen_eff) begin
              w_warm_nxt = r_warm_cnt + 4'd1;
              if (r_warm_cnt + 4'd1 == c_warm_target) begin
                w_state_nxt = ST_LIVE;
                w_miss_nxt  = 4'd0;
              end
            end else begin
              w_warm_nxt = 4'd0;
            end
          end
        end
        ST_LIVE: begin
          if (w_boundary) begin
            if (w_seen_eff) begin
              w_miss_nxt = 4'd0;
            end else begin
              w_miss_nxt = r_miss_cnt + 4'd1;
              if (r_miss_cnt + 4'd1 == c_wdog_target) begin
                w_state_nxt = ST_LOST;
                w_lost_nxt  = (r_lost_cnt != 8'hFF) ? r_lost_cnt + 8'd1 : r_lost_cnt;
              end
            end
          end
        end
        default: begin
          if (w_boundary && w_seen_eff) begin
            w_state_nxt = ST_WARMUP;
            w_warm_nxt  = 4'd0;
          end
        end
      endcase
    end
  end

  // Sync delay line matching the frame-buffer read latency.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_dly <= '1;
      r_vs_dly <= '1;
      r_de_dly <= '0;
    end else begin
      r_hs_dly <= {r_hs_dly[SYNC_DLY-2:0], tim_hs_n};
      r_vs_dly <= {r_vs_dly[SYNC_DLY-2:0], tim_vs_n};
      r_de_dly <= {r_de_dly[SYNC_DLY-2:0], tim_de};
    end
  end

`ifdef TEST_PATTERN_EN
  localparam int               c_x_w   = BAR_SHIFT + 3;
  localparam logic [c_x_w-1:0] c_x_one = 1;
  logic [c_x_w-1:0] r_x;
  logic [2:0]       w_bar_idx;

  // Pixel column counter, taken one stage early so the registered pixel lines up with out_de.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n)                    r_x <= '0;
    else if (r_de_dly[SYNC_DLY-2]) r_x <= r_x + c_x_one;
    else                           r_x <= '0;
  end

  assign w_bar_idx = r_x[BAR_SHIFT+2:BAR_SHIFT];

  // Eight vertical colour bars, white to black.
  always_comb begin
    w_filler = 16'h0000;
    case (w_bar_idx)
      3'd0:    w_filler = 16'hFFFF;
      3'd1:    w_filler = 16'hFFE0;
      3'd2:    w_filler = 16'h07FF;
      3'd3:    w_filler = 16'h07E0;
      3'd4:    w_filler = 16'hF81F;
      3'd5:    w_filler = 16'hF800;
      3'd6:    w_filler = 16'h001F;
      default: w_filler = 16'h0000;
    endcase
  end
`else
  assign w_filler = 16'h0000;
`endif

  // Output pixel: live data only while LIVE and the frame buffer has a valid pixel.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n)                         r_rgb <= 16'h0000;
    else if (r_state == ST_LIVE && fb_de) r_rgb <= fb_data;
    else                                r_rgb <= w_filler;
  end

  assign fb_vs_n  = (r_state == ST_WAIT_CAL) ? 1'b1 : tim_vs_n;
  assign out_hs_n = r_hs_dly[SYNC_DLY-1];
  assign out_vs_n = r_vs_dly[SYNC_DLY-1];
  assign out_de   = r_de_dly[SYNC_DLY-1];
  assign out_rgb  = r_rgb;
  assign state    = r_state;
  assign lost_cnt = r_lost_cnt;

endmodule
`default_nettype wire
